// File: rtl/button_conditioner_if.sv
// Button bundle between raw push-button inputs and the conditioned strobes.
// The master side supplies raw levels; the slave side (the conditioner) returns debounced outputs.
interface button_conditioner_if #(
   parameter int unsigned N_BTN = 8
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_action;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_action
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_action
   );
endinterface

// File: rtl/button_conditioner.sv
// Per-lane 2-FF synchroniser, counter debounce, press/release pulses and hold-to-repeat strobes.
// All lanes are independent; everything runs on clk_100.
module button_conditioner #(
   parameter int unsigned      N_BTN         = 8,
   parameter int unsigned      DB_CYCLES     = 1_000_000,
   parameter int unsigned      REPEAT_DELAY  = 40_000_000,
   parameter int unsigned      REPEAT_PERIOD = 10_000_000,
   parameter logic [N_BTN-1:0] REPEAT_MASK   = '1
) (
   input  logic                 clk_100,
   input  logic                 reset,
   button_conditioner_if.slave  btn
);

   localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
   localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

   localparam logic [DB_W-1:0] DB_TERM = DB_W'(DB_CYCLES - 1);
   localparam logic [RP_W-1:0] RD_TERM = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_TERM = RP_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      REPEAT
   } rp_state_t;

   logic [N_BTN-1:0] sync_s1;
   logic [N_BTN-1:0] sync_s2;

   always_ff @(posedge clk_100 or posedge reset) begin
      if (reset) begin
         sync_s1 <= '0;
         sync_s2 <= '0;
      end else begin
         sync_s1 <= btn.btn_raw;
         sync_s2 <= sync_s1;
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_lane
      logic            level_q;
      logic            press_q;
      logic            release_q;
      logic            action_q;
      logic [DB_W-1:0] db_cnt_q;
      logic [DB_W-1:0] db_cnt_d;
      logic            rise_evt;
      logic            fall_evt;
      logic            rep_evt;

      // Terminal compare uses >= so a corrupted count can only flip, never wrap.
      always_comb begin
         db_cnt_d = '0;
         rise_evt = 1'b0;
         fall_evt = 1'b0;
         if (sync_s2[g] != level_q) begin
            if (db_cnt_q >= DB_TERM) begin
               rise_evt = sync_s2[g];
               fall_evt = ~sync_s2[g];
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
      end

      always_ff @(posedge clk_100 or posedge reset) begin
         if (reset) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            action_q  <= 1'b0;
         end else begin
            db_cnt_q <= db_cnt_d;
            if (rise_evt || fall_evt) begin
               level_q <= sync_s2[g];
            end
            press_q   <= rise_evt;
            release_q <= fall_evt;
            action_q  <= rise_evt | rep_evt;
         end
      end

      if (REPEAT_MASK[g]) begin : g_rep
         rp_state_t       st_q;
         rp_state_t       st_d;
         logic [RP_W-1:0] rp_cnt_q;
         logic [RP_W-1:0] rp_cnt_d;

         // Release is decoded first so it overrides a repeat due on the same edge.
         always_comb begin
            st_d     = st_q;
            rp_cnt_d = rp_cnt_q;
            rep_evt  = 1'b0;
            if (fall_evt) begin
               st_d     = IDLE;
               rp_cnt_d = '0;
            end else begin
               case (st_q)
                  IDLE: begin
                     if (rise_evt) begin
                        st_d     = HOLD;
                        rp_cnt_d = '0;
                     end
                  end
                  HOLD: begin
                     if (rp_cnt_q >= RD_TERM) begin
                        rep_evt  = 1'b1;
                        st_d     = REPEAT;
                        rp_cnt_d = '0;
                     end else begin
                        rp_cnt_d = rp_cnt_q + RP_W'(1);
                     end
                  end
                  REPEAT: begin
                     if (rp_cnt_q >= RP_TERM) begin
                        rep_evt  = 1'b1;
                        rp_cnt_d = '0;
                     end else begin
                        rp_cnt_d = rp_cnt_q + RP_W'(1);
                     end
                  end
                  default: begin
                     st_d     = IDLE;
                     rp_cnt_d = '0;
                  end
               endcase
            end
         end

         always_ff @(posedge clk_100 or posedge reset) begin
            if (reset) begin
               st_q     <= IDLE;
               rp_cnt_q <= '0;
            end else begin
               st_q     <= st_d;
               rp_cnt_q <= rp_cnt_d;
            end
         end
      end else begin : g_norep
         assign rep_evt = 1'b0;
      end

      assign btn.btn_level[g]   = level_q;
      assign btn.btn_press[g]   = press_q;
      assign btn.btn_release[g] = release_q;
      assign btn.btn_action[g]  = action_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner: two instances (full and partial repeat mask)
// share the same raw stimulus; a reference model fills a queue that a negedge monitor drains.
module tb_button_conditioner;

   localparam int unsigned N      = 4;
   localparam int unsigned DB     = 4;
   localparam int unsigned RD     = 20;
   localparam int unsigned RP     = 8;
   localparam logic [N-1:0] MASK_A = 4'b1111;
   localparam logic [N-1:0] MASK_B = 4'b1110;

   logic         clk_100 = 1'b0;
   logic         reset   = 1'b1;
   logic [N-1:0] raw     = '0;

   int checks = 0;
   int errors = 0;

   button_conditioner_if #(.N_BTN(N)) bus_a ();
   button_conditioner_if #(.N_BTN(N)) bus_b ();

   assign bus_a.btn_raw = raw;
   assign bus_b.btn_raw = raw;

   button_conditioner #(
      .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK_A)
   ) dut_a (
      .clk_100(clk_100), .reset(reset), .btn(bus_a.slave)
   );

   button_conditioner #(
      .N_BTN(N), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK_B)
   ) dut_b (
      .clk_100(clk_100), .reset(reset), .btn(bus_b.slave)
   );

   always #5 clk_100 = ~clk_100;

   // Reference model: level flips once the last DB synchronised samples all disagree with it;
   // repeats fall at press_edge + RD + k*RP while held, unless that edge is the release edge.
   logic [N-1:0] m_s1 = '0;
   logic [N-1:0] m_s2 = '0;
   logic [N-1:0] m_level = '0;
   logic [31:0]  m_hist [N];
   longint       m_press_edge [N];
   longint       edge_n = 0;
   logic [31:0]  exp_q [$];

   always @(posedge clk_100) begin
      logic [N-1:0] lvl, prs, rel, act_a, act_b;
      logic         all1, all0, rep;
      longint       t;
      edge_n++;
      if (reset) begin
         m_s1    = '0;
         m_s2    = '0;
         m_level = '0;
         for (int l = 0; l < N; l++) begin
            m_hist[l]       = '0;
            m_press_edge[l] = 0;
         end
         exp_q.push_back('0);
      end else begin
         for (int l = 0; l < N; l++) begin
            m_hist[l] = {m_hist[l][30:0], m_s2[l]};
            all1 = 1'b1;
            all0 = 1'b1;
            for (int k = 0; k < DB; k++) begin
               if (m_hist[l][k]) all0 = 1'b0;
               else              all1 = 1'b0;
            end
            prs[l] = !m_level[l] && all1;
            rel[l] = m_level[l] && all0;
            t      = edge_n - m_press_edge[l];
            rep    = m_level[l] && !rel[l] && (t >= RD) && (((t - RD) % RP) == 0);
            act_a[l] = prs[l] | (rep & MASK_A[l]);
            act_b[l] = prs[l] | (rep & MASK_B[l]);
            if (prs[l]) begin
               m_level[l]      = 1'b1;
               m_press_edge[l] = edge_n;
            end
            if (rel[l]) m_level[l] = 1'b0;
            lvl[l] = m_level[l];
         end
         m_s2 = m_s1;
         m_s1 = raw;
         exp_q.push_back({act_b, rel, prs, lvl, act_a, rel, prs, lvl});
      end
   end

   // Event counters used by the directed scenarios.
   int c_act0_a = 0, c_act0_b = 0, c_prs0_a = 0, c_lane1_any = 0;
   int c_rel2_a = 0, c_act2_a = 0, c_both03 = 0;

   always @(negedge clk_100) begin
      logic [31:0] e;
      logic [15:0] got_a, got_b;
      got_a = {bus_a.btn_action, bus_a.btn_release, bus_a.btn_press, bus_a.btn_level};
      got_b = {bus_b.btn_action, bus_b.btn_release, bus_b.btn_press, bus_b.btn_level};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_underflow: got empty queue, required an entry (edge %0d)", edge_n);
      end else begin
         e = exp_q.pop_front();
         if (reset) e = '0;
         if (got_a !== e[15:0]) begin
            errors++;
            $display("FAIL dut_a_outputs: got %h, required %h (edge %0d)", got_a, e[15:0], edge_n);
         end
         checks++;
         if (got_b !== e[31:16]) begin
            errors++;
            $display("FAIL dut_b_outputs: got %h, required %h (edge %0d)", got_b, e[31:16], edge_n);
         end
      end
      c_act0_a    += int'(bus_a.btn_action[0]);
      c_act0_b    += int'(bus_b.btn_action[0]);
      c_prs0_a    += int'(bus_a.btn_press[0]);
      c_lane1_any += int'(bus_a.btn_press[1] | bus_a.btn_release[1] | bus_a.btn_action[1] | bus_a.btn_level[1]);
      c_rel2_a    += int'(bus_a.btn_release[2]);
      c_act2_a    += int'(bus_a.btn_action[2]);
      c_both03    += int'(bus_a.btn_press[0] & bus_a.btn_press[3]);
   end

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_100);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b0, b1, b2, b3;
      tick(3);
      check("reset_outputs_a", int'({bus_a.btn_level, bus_a.btn_press, bus_a.btn_action}), 0);
      reset = 1'b0;
      tick(3);

      // Held press on lane 0: actions at edges 6, 26, 34, 42; masked lane gives only the press.
      b0 = c_act0_a; b1 = c_act0_b; b2 = c_prs0_a;
      raw[0] = 1'b1;
      tick(48);
      check("hold_actions_lane0", c_act0_a - b0, 4);
      check("masked_actions_lane0", c_act0_b - b1, 1);
      check("hold_press_lane0", c_prs0_a - b2, 1);
      raw[0] = 1'b0;
      tick(10);

      // Short glitches on lane 1 never reach the debounced level.
      b0 = c_lane1_any;
      for (int k = 0; k < 50; k++) begin
         raw[1] = (k % 3 == 0);
         tick(1);
      end
      raw[1] = 1'b0;
      tick(8);
      check("glitch_lane1_activity", c_lane1_any - b0, 0);

      // Lane 2 released so the debounced fall lands on a due repeat (edge 34).
      b0 = c_rel2_a; b1 = c_act2_a;
      raw[2] = 1'b1;
      tick(28);
      raw[2] = 1'b0;
      tick(14);
      check("release_lane2", c_rel2_a - b0, 1);
      check("actions_lane2", c_act2_a - b1, 2);

      // Simultaneous presses on lanes 0 and 3.
      b0 = c_both03;
      raw[0] = 1'b1;
      raw[3] = 1'b1;
      tick(8);
      check("simultaneous_press_03", c_both03 - b0, 1);
      raw = '0;
      tick(10);

      // Reset while lane 0 is repeating, then a fresh debounce with the button still held.
      raw[0] = 1'b1;
      tick(30);
      #2 reset = 1'b1;
      #1;
      check("async_reset_a", int'({bus_a.btn_level, bus_a.btn_press, bus_a.btn_action}), 0);
      check("async_reset_b", int'({bus_b.btn_level, bus_b.btn_press, bus_b.btn_action}), 0);
      tick(3);
      reset = 1'b0;
      b3 = c_prs0_a;
      tick(8);
      check("press_after_reset", c_prs0_a - b3, 1);
      raw = '0;
      tick(10);

      // Random toggling: fast phase exercises glitch rejection, slow phase exercises repeats.
      for (int k = 0; k < 800; k++) begin
         for (int l = 0; l < N; l++)
            if ($urandom_range(0, 99) < 10) raw[l] = ~raw[l];
         tick(1);
      end
      for (int k = 0; k < 1500; k++) begin
         for (int l = 0; l < N; l++)
            if ($urandom_range(0, 99) < 2) raw[l] = ~raw[l];
         tick(1);
      end
      raw = '0;
      tick(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
